mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter_rr.sv | 14 +
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter.
// Physical RAM size and FSM state encodings live here.
package mem_arbiter_pkg;

    localparam int RAM_SIZE_LOG = 10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RDWAIT = 2'd2;

    // Port 1 counts as last granted out of reset, so port 0 wins the first tie.
    localparam logic LAST_RESET = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin winner selection.
// On a tie, the port not granted most recently wins.
module mem_arb_rr (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner,
    output logic valid
);

    assign valid  = req0 | req1;
    assign winner = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / loader) single-outstanding memory arbiter.
// One access at a time: IDLE -> ACCESS -> (RDWAIT) -> IDLE.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int AW     = RAM_SIZE_LOG
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    logic [1:0]        state;
    logic              winner_q;
    logic              we_q;
    logic              oor_q;
    logic              last_q;
    logic              rr_winner;
    logic              rr_valid;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              we_sel;
    logic              oor_sel;
    logic              in_access;
    logic              in_rdwait;

    mem_arb_rr u_rr (
        .req0   (req0_i),
        .req1   (req1_i),
        .last   (last_q),
        .winner (rr_winner),
        .valid  (rr_valid)
    );

    assign addr_sel  = rr_winner ? addr1_i  : addr0_i;
    assign wdata_sel = rr_winner ? wdata1_i : wdata0_i;
    assign we_sel    = rr_winner ? we1_i    : we0_i;
    // Any address bit above the physical RAM range flags an error.
    assign oor_sel   = |(addr_sel >> AW);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= ST_IDLE;
            winner_q   <= 1'b0;
            we_q       <= 1'b0;
            oor_q      <= 1'b0;
            last_q     <= LAST_RESET;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (rr_valid) begin
                        state      <= ST_ACCESS;
                        winner_q   <= rr_winner;
                        last_q     <= rr_winner;
                        we_q       <= we_sel;
                        oor_q      <= oor_sel;
                        mem_addr_o <= addr_sel[AW-1:0];
                        mem_data_o <= wdata_sel;
                    end
                end
                ST_ACCESS: begin
                    state <= (we_q || oor_q) ? ST_IDLE : ST_RDWAIT;
                end
                ST_RDWAIT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_access = (state == ST_ACCESS);
    assign in_rdwait = (state == ST_RDWAIT);

    assign gnt0_o    = in_access & ~winner_q;
    assign gnt1_o    = in_access &  winner_q;
    assign err_o     = in_access &  oor_q;
    assign mem_we_o  = in_access &  we_q & ~oor_q;
    assign rvalid0_o = in_rdwait & ~winner_q;
    assign rvalid1_o = in_rdwait &  winner_q;
    assign rdata_o   = in_rdwait ? mem_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level arbitration/latency model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int DW    = 16;
    localparam int ADW   = 16;
    localparam int AWL   = RAM_SIZE_LOG;
    localparam int DEPTH = 1 << AWL;

    logic           clk;
    logic           rst_i;
    logic           r_req   [2];
    logic           r_we    [2];
    logic [ADW-1:0] r_addr  [2];
    logic [DW-1:0]  r_wdata [2];
    logic           gnt0, gnt1, rvalid0, rvalid1, err;
    logic [DW-1:0]  rdata;
    logic [AWL-1:0] mem_addr;
    logic [DW-1:0]  mem_data;
    logic           mem_we;
    logic [DW-1:0]  mem_rd;

    mem_arbiter dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req0_i     (r_req[0]),
        .req1_i     (r_req[1]),
        .we0_i      (r_we[0]),
        .we1_i      (r_we[1]),
        .addr0_i    (r_addr[0]),
        .addr1_i    (r_addr[1]),
        .wdata0_i   (r_wdata[0]),
        .wdata1_i   (r_wdata[1]),
        .gnt0_o     (gnt0),
        .gnt1_o     (gnt1),
        .rvalid0_o  (rvalid0),
        .rvalid1_o  (rvalid1),
        .rdata_o    (rdata),
        .err_o      (err),
        .mem_addr_o (mem_addr),
        .mem_data_o (mem_data),
        .mem_we_o   (mem_we),
        .mem_data_i (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read data valid one cycle after the address.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data;
        mem_rd <= mem[mem_addr];
    end

    typedef struct packed {
        logic           g0, g1, err, we, rv0, rv1, has_addr;
        logic [DW-1:0]  rdata;
        logic [AWL-1:0] addr;
        logic [DW-1:0]  wdata;
    } exp_t;

    typedef struct packed {
        logic           we;
        logic [ADW-1:0] addr;
        logic [DW-1:0]  data;
    } txn_t;

    exp_t          ring [4];
    logic [DW-1:0] ref_mem [DEPTH];
    txn_t          q0[$];
    txn_t          q1[$];
    int            gnt_hist[$];
    int            gnt_cyc[$];
    int            rv_cnt [2];
    int            tests, fails, cyc, next_arb;
    logic          last_m;
    bit            rnd_mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) ring[i] = '0;
        next_arb = 0;
        last_m   = 1'b1;
    endtask

    // Accept at edge c: grant during cycle c, read data during c+1.
    // Next arbitration edge is c+2 after a write/error, c+3 after a read.
    task automatic model_step();
        int   w;
        int   a;
        bit   bad;
        exp_t e;
        if (rst_i !== 1'b1) return;
        if (cyc < next_arb || !(r_req[0] || r_req[1])) return;
        if (r_req[0] && r_req[1]) w = (last_m == 1'b1) ? 0 : 1;
        else w = r_req[1] ? 1 : 0;
        last_m = w[0];
        a      = int'(r_addr[w]);
        bad    = (a >= DEPTH);
        e            = ring[cyc % 4];
        e.g0         = (w == 0);
        e.g1         = (w == 1);
        e.err        = bad;
        e.we         = r_we[w] && !bad;
        e.has_addr   = 1'b1;
        e.addr       = AWL'(a % DEPTH);
        e.wdata      = r_wdata[w];
        ring[cyc % 4] = e;
        gnt_hist.push_back(w);
        gnt_cyc.push_back(cyc);
        if (!bad && r_we[w]) ref_mem[a] = r_wdata[w];
        if (!bad && !r_we[w]) begin
            e       = ring[(cyc + 1) % 4];
            e.rv0   = (w == 0);
            e.rv1   = (w == 1);
            e.rdata = ref_mem[a];
            ring[(cyc + 1) % 4] = e;
            next_arb = cyc + 3;
        end else begin
            next_arb = cyc + 2;
        end
    endtask

    task automatic check();
        exp_t e;
        e = ring[cyc % 4];
        chk("gnt0", gnt0, e.g0);
        chk("gnt1", gnt1, e.g1);
        chk("err", err, e.err);
        chk("mem_we", mem_we, e.we);
        chk("rvalid0", rvalid0, e.rv0);
        chk("rvalid1", rvalid1, e.rv1);
        if (e.rv0 || e.rv1) chk("rdata", rdata, e.rdata);
        else chk("rdata_idle", rdata, 0);
        if (e.has_addr) chk("mem_addr", mem_addr, e.addr);
        if (e.we) chk("mem_data", mem_data, e.wdata);
        if (rvalid0) rv_cnt[0]++;
        if (rvalid1) rv_cnt[1]++;
        ring[cyc % 4] = '0;
    endtask

    task automatic issue(input int p, input txn_t t);
        r_req[p]   = 1'b1;
        r_we[p]    = t.we;
        r_addr[p]  = t.addr;
        r_wdata[p] = t.data;
    endtask

    task automatic drive_port(input int p);
        logic g;
        bit   dropped;
        txn_t t;
        g       = (p == 0) ? gnt0 : gnt1;
        dropped = 1'b0;
        if (r_req[p] && g) begin
            r_req[p] = 1'b0;
        end else if (r_req[p] && rnd_mode && $urandom_range(0, 15) == 0) begin
            r_req[p] = 1'b0;
            dropped  = 1'b1;
        end
        if (!r_req[p] && !dropped) begin
            if (p == 0 && q0.size() > 0) begin
                issue(p, q0.pop_front());
            end else if (p == 1 && q1.size() > 0) begin
                issue(p, q1.pop_front());
            end else if (rnd_mode && $urandom_range(0, 2) == 0) begin
                t.we   = 1'($urandom_range(0, 1));
                t.addr = ($urandom_range(0, 7) == 0)
                       ? ADW'((1 << ($urandom_range(AWL, ADW - 1))) | $urandom_range(0, 31))
                       : ADW'($urandom_range(0, 31));
                t.data = DW'($urandom);
                issue(p, t);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        drive_port(0);
        drive_port(1);
        @(negedge clk);
        check();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(!r_req[0] && !r_req[1] && q0.size() == 0 && q1.size() == 0
                 && cyc >= next_arb) && n < 200) begin
            step();
            n++;
        end
        chk("idle_timeout", n < 200, 1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_rv0", rvalid0, 0);
        chk("rst_rv1", rvalid1, 0);
        chk("rst_err", err, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_rdata", rdata, 0);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        #1;
        chk_reset_outputs();
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        q0.delete();
        q1.delete();
        model_clear();
        step();
        step();
        rst_i = 1'b1;
    endtask

    initial begin
        int   base;
        int   start;
        int   n;
        logic [DW-1:0] old;
        txn_t t;
        tests    = 0;
        fails    = 0;
        cyc      = 0;
        rnd_mode = 1'b0;
        rv_cnt[0] = 0;
        rv_cnt[1] = 0;
        for (int p = 0; p < 2; p++) begin
            r_req[p]   = 1'b0;
            r_we[p]    = 1'b0;
            r_addr[p]  = '0;
            r_wdata[p] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = DW'(i * 257) ^ 16'h00A5;
            ref_mem[i] = DW'(i * 257) ^ 16'h00A5;
        end
        mem[16]     = 16'hBEEF;
        ref_mem[16] = 16'hBEEF;
        model_clear();
        rst_i = 1'b1;
        #2;
        do_reset();

        // Single CPU read.
        q0.push_back('{we: 1'b0, addr: 16'h0010, data: 16'h0});
        wait_idle();
        chk("t1_rv0_cnt", rv_cnt[0], 1);
        chk("t1_rv1_cnt", rv_cnt[1], 0);

        // Simultaneous writes straight out of reset, then readback.
        do_reset();
        base = gnt_hist.size();
        q0.push_back('{we: 1'b1, addr: 16'h0001, data: 16'h1111});
        q1.push_back('{we: 1'b1, addr: 16'h0002, data: 16'h2222});
        wait_idle();
        chk("t2_first", gnt_hist[base], 0);
        chk("t2_second", gnt_hist[base + 1], 1);
        chk("t2_gap", gnt_cyc[base + 1] - gnt_cyc[base], 2);
        q0.push_back('{we: 1'b0, addr: 16'h0001, data: 16'h0});
        q1.push_back('{we: 1'b0, addr: 16'h0002, data: 16'h0});
        wait_idle();
        chk("t2_mem1", mem[1], 16'h1111);
        chk("t2_mem2", mem[2], 16'h2222);

        // Both ports streaming reads: grants must alternate.
        rv_cnt[0] = 0;
        rv_cnt[1] = 0;
        base  = gnt_hist.size();
        start = (last_m == 1'b1) ? 0 : 1;
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{we: 1'b0, addr: ADW'(32 + i), data: 16'h0});
            q1.push_back('{we: 1'b0, addr: ADW'(48 + i), data: 16'h0});
        end
        wait_idle();
        for (int i = 0; i < 8; i++)
            chk("t3_alt", gnt_hist[base + i], start ^ (i % 2));
        chk("t3_rv0_cnt", rv_cnt[0], 4);
        chk("t3_rv1_cnt", rv_cnt[1], 4);

        // Out-of-range write from port 1 must not touch RAM.
        old = ref_mem[5];
        q1.push_back('{we: 1'b1, addr: ADW'((1 << AWL) | 5), data: 16'hDEAD});
        wait_idle();
        chk("t4_mem_kept", mem[5], old);

        // Reset while a read is in its data cycle.
        q0.push_back('{we: 1'b0, addr: 16'h0020, data: 16'h0});
        n = 0;
        while (!rvalid0 && n < 20) begin
            step();
            n++;
        end
        chk("t5_reach_rdwait", rvalid0, 1);
        do_reset();
        rv_cnt[0] = 0;
        rv_cnt[1] = 0;
        base = gnt_hist.size();
        q0.push_back('{we: 1'b0, addr: 16'h0010, data: 16'h0});
        q1.push_back('{we: 1'b0, addr: 16'h0011, data: 16'h0});
        wait_idle();
        chk("t5_tie_p0", gnt_hist[base], 0);
        chk("t5_rv0_cnt", rv_cnt[0], 1);
        chk("t5_rv1_cnt", rv_cnt[1], 1);

        // Random mixed traffic.
        rnd_mode = 1'b1;
        for (int i = 0; i < 600; i++) step();
        rnd_mode = 1'b0;
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        wait_idle();
        for (int i = 0; i < 32; i++) begin
            t.we = 1'b0;
            t.addr = ADW'(i);
            q0.push_back(t);
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
